// File: rtl/afifo_pkte.sv
// Shared types and defaults for the FIFO write-port arbiter.
package afifo_pkte;

    // Word carried by each producer and written into the FIFO.
    typedef logic [7:0] data_ty;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int unsigned ARB_NUM_REQ   = 4;
    localparam int unsigned ARB_MAX_BURST = 4;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: returns the first set request at or above rr_ptr, wrapping.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               any_req
);

    // Scan from the farthest position back to rr_ptr so the nearest set bit is written last.
    always_comb begin
        logic [IDX_W-1:0] pos;
        pos     = '0;
        idx     = '0;
        any_req = |req;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            pos = IDX_W'((32'(rr_ptr) + 32'(i)) % NUM_REQ);
            if (req[pos]) begin
                idx = pos;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NUM_REQ valid/ready producers.
// Each grant lasts up to MAX_BURST pushes; a full FIFO stalls the burst without ending it.
// DATA_W must equal $bits(data_ty).
module fifo_wr_arbiter
    import afifo_pkte::*;
#(
    parameter int unsigned NUM_REQ   = ARB_NUM_REQ,
    parameter int unsigned DATA_W    = $bits(data_ty),
    parameter int unsigned MAX_BURST = ARB_MAX_BURST
) (
    input  logic                       wr_clk,
    input  logic                       wr_rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  data_ty [NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       fifo_full,
    output logic                       fifo_wr_en,
    output logic [DATA_W-1:0]          fifo_wr_data,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic [15:0]                push_cnt
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [15:0]      push_cnt_q, push_cnt_d;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req     (req_valid),
        .rr_ptr  (rr_ptr_q),
        .idx     (pick_idx),
        .any_req (pick_any)
    );

    // Next-state and write-side outputs; handshake outputs are combinational from state.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        burst_cnt_d  = burst_cnt_q;
        push_cnt_d   = push_cnt_q;
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d     = BURST;
                    grant_d     = pick_idx;
                    burst_cnt_d = '0;
                end
            end
            BURST: begin
                req_ready[grant_q] = !fifo_full;
                fifo_wr_en         = req_valid[grant_q] && !fifo_full;
                fifo_wr_data       = req_data[grant_q];
                if (fifo_wr_en) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                    push_cnt_d  = push_cnt_q + 16'd1;
                end
                // A stalled last word keeps the burst open; only a real push can close it.
                if (!req_valid[grant_q] ||
                    (fifo_wr_en && (burst_cnt_q == CNT_W'(MAX_BURST - 1)))) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge wr_clk or negedge wr_rst) begin
        if (!wr_rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            push_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            push_cnt_q  <= push_cnt_d;
        end
    end

    assign grant_id = grant_q;
    assign busy     = (state_q == BURST);
    assign push_cnt = push_cnt_q;

`ifndef SYNTHESIS
    a_no_write_when_full: assert property (@(posedge wr_clk) disable iff (!wr_rst)
        fifo_wr_en |-> !fifo_full);
    a_ready_onehot0: assert property (@(posedge wr_clk) disable iff (!wr_rst)
        $onehot0(req_ready));
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: producer models feed queued words, the monitor
// checks every FIFO write against expected words pushed when the stimulus was issued.
module tb_fifo_wr_arbiter;
    import afifo_pkte::*;

    logic         wr_clk;
    logic         wr_rst;
    logic [3:0]   req_valid;
    data_ty [3:0] req_data;
    logic [3:0]   req_ready;
    logic         fifo_full;
    logic         fifo_wr_en;
    logic [7:0]   fifo_wr_data;
    logic [1:0]   grant_id;
    logic         busy;
    logic [15:0]  push_cnt;

    fifo_wr_arbiter #(
        .NUM_REQ   (4),
        .DATA_W    (8),
        .MAX_BURST (4)
    ) dut (
        .wr_clk       (wr_clk),
        .wr_rst       (wr_rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .grant_id     (grant_id),
        .busy         (busy),
        .push_cnt     (push_cnt)
    );

    // Producer word queues; bit 8 marks a one-cycle valid gap.
    logic [8:0]  pq [0:3][$];
    // Random-phase expected words per producer.
    logic [7:0]  rq [0:3][$];
    // Directed-phase expected writes in global order: {grant, data}.
    logic [10:0] expg[$];
    int          wcyc[$];
    logic [3:0]  fire;
    int          cyc;
    int          wr_count;
    bit          rand_mode;
    int          n_pass;
    int          n_total;
    int          seq[4];

    initial begin
        wr_clk = 1'b0;
        forever #5 wr_clk = ~wr_clk;
    end

    always @(posedge wr_clk) cyc <= cyc + 1;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    task automatic drive_prod();
        for (int k = 0; k < 4; k++) begin
            if (pq[k].size() > 0 && !pq[k][0][8]) begin
                req_valid[k] = 1'b1;
                req_data[k]  = pq[k][0][7:0];
            end else begin
                req_valid[k] = 1'b0;
                req_data[k]  = 8'hA5;
            end
        end
    endtask

    task automatic load(input int k, input logic [7:0] d);
        pq[k].push_back({1'b0, d});
        expg.push_back({3'(k), d});
    endtask

    task automatic load_gap(input int k);
        pq[k].push_back(9'h100);
    endtask

    task automatic apply_reset();
        wr_rst    = 1'b0;
        fifo_full = 1'b0;
        for (int k = 0; k < 4; k++) begin
            pq[k].delete();
            rq[k].delete();
        end
        expg.delete();
        wcyc.delete();
        wr_count = 0;
        drive_prod();
        repeat (2) @(posedge wr_clk);
        #3 wr_rst = 1'b1;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ready"}, req_ready, 0);
        chk({tag, "_wr_en"}, fifo_wr_en, 0);
        chk({tag, "_grant"}, grant_id, 0);
        chk({tag, "_push_cnt"}, push_cnt, 0);
        chk({tag, "_wr_data"}, fifo_wr_data, 0);
    endtask

    task automatic wait_idle(input int max, input string name);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        while (!done && n < max) begin
            @(posedge wr_clk);
            #3;
            n++;
            done = !busy && expg.size() == 0;
            for (int k = 0; k < 4; k++) begin
                if (pq[k].size() != 0 || rq[k].size() != 0) done = 1'b0;
            end
        end
        chk({name, "_drained"}, done, 1);
    endtask

    // Producer model update: consume gap markers and accepted words, then redrive.
    always @(posedge wr_clk) begin
        #1;
        for (int k = 0; k < 4; k++) begin
            if (pq[k].size() > 0) begin
                if (pq[k][0][8]) void'(pq[k].pop_front());
                else if (fire[k]) void'(pq[k].pop_front());
            end
        end
        fire = '0;
        drive_prod();
    end

    // Monitor: sample handshakes and check outputs mid-cycle.
    always @(negedge wr_clk) begin
        logic [10:0] e;
        logic [1:0]  id;
        if (wr_rst) begin
            fire = req_valid & req_ready;
            if (busy) begin
                chk("ready_rule", req_ready, fifo_full ? 4'b0 : (4'b1 << grant_id));
                chk("wr_en_rule", fifo_wr_en, req_valid[grant_id] & !fifo_full);
                chk("ready_onehot0", $onehot0(req_ready), 1);
            end else begin
                chk("idle_outputs", {req_ready, fifo_wr_en, fifo_wr_data}, 0);
            end
            if (fifo_wr_en) begin
                wr_count++;
                wcyc.push_back(cyc);
                chk("wr_not_full", fifo_full, 0);
                if (!rand_mode) begin
                    chk("exp_avail", expg.size() > 0, 1);
                    if (expg.size() > 0) begin
                        e = expg.pop_front();
                        chk("wr_data", fifo_wr_data, e[7:0]);
                        chk("wr_grant", grant_id, e[10:8]);
                    end
                end else begin
                    id = fifo_wr_data[7:6];
                    chk("rand_grant", grant_id, id);
                    chk("rand_avail", rq[id].size() > 0, 1);
                    if (rq[id].size() > 0) chk("rand_order", fifo_wr_data, rq[id].pop_front());
                end
            end
        end
    end

    initial begin
        int load_cyc;
        logic [7:0] w;
        n_pass    = 0;
        n_total   = 0;
        cyc       = 0;
        wr_count  = 0;
        rand_mode = 1'b0;
        fire      = '0;
        fifo_full = 1'b0;
        wr_rst    = 1'b1;
        drive_prod();
        #3 wr_rst = 1'b0;
        #1 reset_checks("por");
        repeat (2) @(posedge wr_clk);
        #3 wr_rst = 1'b1;

        // Single producer: two bursts of 4 with one bubble, latency 1.
        @(posedge wr_clk);
        #2;
        for (int i = 0; i < 8; i++) load(0, 8'h10 + 8'(i));
        drive_prod();
        load_cyc = cyc;
        wait_idle(100, "single");
        chk("single_push_cnt", push_cnt, 8);
        chk("single_nwr", wcyc.size(), 8);
        if (wcyc.size() == 8) begin
            chk("single_latency", wcyc[0] - load_cyc, 1);
            chk("single_burst1_len", wcyc[3] - wcyc[0], 3);
            chk("single_bubble", wcyc[4] - wcyc[3], 2);
            chk("single_burst2_len", wcyc[7] - wcyc[4], 3);
        end

        // Round-robin: all four valid from rr_ptr=0, grants in order 0,1,2,3.
        apply_reset();
        @(posedge wr_clk);
        #2;
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 4; i++) load(k, {4'(k), 4'(i)});
        drive_prod();
        wait_idle(200, "rr");
        chk("rr_push_cnt", push_cnt, 16);

        // Full stall during producer 2 burst.
        apply_reset();
        @(posedge wr_clk);
        #2;
        for (int i = 0; i < 4; i++) load(2, 8'h20 + 8'(i));
        drive_prod();
        @(posedge wr_clk);
        @(posedge wr_clk);
        #2 fifo_full = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge wr_clk);
            chk("stall_wr_en", fifo_wr_en, 0);
            chk("stall_ready2", req_ready[2], 0);
            chk("stall_grant", grant_id, 2);
            chk("stall_busy", busy, 1);
        end
        chk("stall_push_cnt", push_cnt, 1);
        @(posedge wr_clk);
        #2 fifo_full = 1'b0;
        wait_idle(100, "stall");
        chk("stall_push_total", push_cnt, 4);

        // Early release: producer 1 drops valid after 2 words; producer 3 goes next.
        apply_reset();
        @(posedge wr_clk);
        #2;
        pq[1].push_back(9'h040);
        pq[1].push_back(9'h041);
        load_gap(1);
        pq[1].push_back(9'h042);
        pq[1].push_back(9'h043);
        for (int i = 0; i < 4; i++) pq[3].push_back({1'b0, 8'h60 + 8'(i)});
        expg.push_back({3'd1, 8'h40});
        expg.push_back({3'd1, 8'h41});
        for (int i = 0; i < 4; i++) expg.push_back({3'd3, 8'h60 + 8'(i)});
        expg.push_back({3'd1, 8'h42});
        expg.push_back({3'd1, 8'h43});
        drive_prod();
        wait_idle(100, "early");
        chk("early_push_cnt", push_cnt, 8);

        // Random valid gaps and full traffic; per-producer order via tagged data.
        apply_reset();
        rand_mode = 1'b1;
        for (int k = 0; k < 4; k++) seq[k] = 0;
        for (int c = 0; c < 10000; c++) begin
            @(posedge wr_clk);
            #2;
            for (int k = 0; k < 4; k++) begin
                if (pq[k].size() < 4 && $urandom_range(0, 3) != 0) begin
                    if ($urandom_range(0, 4) == 0) begin
                        load_gap(k);
                    end else begin
                        w = {2'(k), 6'(seq[k])};
                        seq[k]++;
                        pq[k].push_back({1'b0, w});
                        rq[k].push_back(w);
                    end
                end
            end
            fifo_full = ($urandom_range(0, 3) == 0);
            drive_prod();
        end
        @(posedge wr_clk);
        #2 fifo_full = 1'b0;
        wait_idle(2000, "rand");
        chk("rand_push_cnt", push_cnt, 16'(wr_count));
        rand_mode = 1'b0;

        // Reset mid-burst of producer 3: everything clears immediately.
        apply_reset();
        @(posedge wr_clk);
        #2;
        for (int i = 0; i < 4; i++) load(3, 8'h70 + 8'(i));
        drive_prod();
        @(posedge wr_clk);
        @(posedge wr_clk);
        #3;
        chk("mid_busy_before", busy, 1);
        chk("mid_grant_before", grant_id, 3);
        chk("mid_push_before", push_cnt, 1);
        wr_rst = 1'b0;
        #1 reset_checks("mid");
        apply_reset();
        repeat (3) @(posedge wr_clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that shares the single write port of fifo_top among NUM_REQ producers, all in the write clock domain.
- Each producer uses a valid/ready handshake. The arbiter grants one producer at a time for a burst of up to MAX_BURST words, then passes the grant on.
- Honours the FIFO full flag so no write is ever issued into a full FIFO.
- Sits between the producers and fifo_top's write side (wr_en, data_in, full).

Parameters:
- NUM_REQ, 4, number of producers (2..8).
- DATA_W, 8, word width; must equal $bits(data_ty).
- MAX_BURST, 4, maximum words pushed per grant (1..16).

Ports:
- wr_clk  in  1  write-domain clock; all logic is on the rising edge.
- wr_rst  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-producer word-available flag.
- req_data  in  NUM_REQ x DATA_W  per-producer data, packed array of data_ty.
- req_ready  out  NUM_REQ  per-producer accept strobe; a word transfers when valid and ready are both high.
- fifo_full  in  1  FIFO full flag, already in the wr_clk domain.
- fifo_wr_en  out  1  write strobe to the FIFO.
- fifo_wr_data  out  DATA_W  write data to the FIFO.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last granted producer.
- busy  out  1  high while in BURST.
- push_cnt  out  16  total words written since reset; wraps at 2^16.

Behaviour:
- FSM has two states: IDLE and BURST.
- Reset (wr_rst low) takes effect immediately, regardless of clock:
  - state=IDLE, rr_ptr=0, grant_id=0, burst_cnt=0, push_cnt=0.
  - busy, fifo_wr_en and req_ready are all 0; fifo_wr_data=0.
- Reset mid-burst aborts the burst. No partial-word side effects remain.
- IDLE:
  - req_ready=0 and fifo_wr_en=0.
  - If any req_valid bit is set, pick the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - On the next edge: register grant_id to the picked index, clear burst_cnt, go to BURST.
  - Arbitration latency is exactly 1 cycle from valid to BURST.
- BURST, with g = grant_id:
  - req_ready[g] = !fifo_full. All other req_ready bits are 0.
  - fifo_wr_en = req_valid[g] && !fifo_full.
  - fifo_wr_data = req_data[g] whenever in BURST; it is 0 in IDLE.
  - These outputs are combinational from registered state and inputs, with zero latency.
  - On each push: burst_cnt++ and push_cnt++.
- Burst termination, taking effect at the edge:
  - If a push occurs with burst_cnt==MAX_BURST-1, or req_valid[g]==0, go to IDLE.
  - On that transition set rr_ptr = (g+1) mod NUM_REQ.
  - One bubble cycle follows each burst; this is intended.
- fifo_full high in BURST: stall. No push, no counter change, grant held.
  - This applies even on the last word of a burst: the burst waits and does not end.
- Producer drops valid while stalled: the burst ends on that edge (handled by the req_valid[g]==0 rule above).
- A producer that does not hold valid is skipped. If only one producer requests, it is re-granted after each bubble.
- Simultaneous fifo_full rise and final push: fifo_full wins and no write occurs.
- Never push to a non-granted producer. Never assert more than one req_ready bit.
- Assertions the implementation must include:
  - fifo_wr_en implies !fifo_full.
  - $onehot0(req_ready).

Decomposition:
- Package afifo_pkte carries these shared definitions:
  - data_ty, already defined there.
  - typedef arb_state_t enum {IDLE, BURST}.
  - localparam ARB_NUM_REQ=4.
  - localparam ARB_MAX_BURST=4.
- Sub-module rr_pick: combinational rotate-priority encoder.
  - Inputs: req vector and rr_ptr.
  - Outputs: index and any_req.
  - Instantiated once.

Test Plan:
- Reset: drive wr_rst low mid-BURST -> busy=0, req_ready=0, fifo_wr_en=0 and grant_id=0 immediately; push_cnt=0.
- Single producer: req 0 continuous with data 0x10..0x17 -> two bursts of 4 writes each separated by a 1-cycle bubble; FIFO holds 0x10..0x17 in order; push_cnt=8.
- Round-robin: all 4 valid, each with 4 words (producer k sends 0xk0..0xk3) -> grant order 0,1,2,3; FIFO contents 0x00..0x03, 0x10..0x13, 0x20..0x23, 0x30..0x33.
- Full stall: fill FIFO to 16 entries, hold fifo_full for 10 cycles during a burst of producer 2 -> no fifo_wr_en; req_ready[2]=0; grant_id=2 held; burst resumes and completes after full drops.
- Early release: producer 1 sends 2 words then drops valid, while producer 3 is valid -> BURST ends after 2 pushes; the next grant goes to 3, not 1.
- Overflow guard: random valid and full traffic for 10000 cycles -> both assertions hold; the scoreboard matches per-producer order; push_cnt equals the FIFO write count.
